// File: rtl/motion_bbox.sv
// ---------------------------------------------------------------------------
// motion_bbox
//
// Per-frame bounding box and set-pixel count for a binary motion mask.
// The block sits downstream of the dilator and takes one mask pixel per clock
// together with its raster position. At the end of each frame it publishes the
// box, the count and a motion flag on a valid/ready result port.
//
// Ports
//   clk         pixel clock
//   rst_n       asynchronous reset, active low
//   hpos        column of in_pix (already aligned to in_pix by the caller)
//   vpos        line of in_pix
//   in_pix      dilated mask pixel, 1 = motion
//   res_valid   a published result is available
//   res_ready   consumer accepts the result when res_valid & res_ready
//   res_x_min   leftmost set column
//   res_x_max   rightmost set column
//   res_y_min   top set line
//   res_y_max   bottom set line
//   res_count   number of set pixels in the frame (saturating)
//   res_motion  res_count >= MIN_PIXELS
//   res_ovr     sticky: a result was replaced before it was accepted
//
// Notes
//   The block does not need a gap-free raster. It only looks at three things:
//   the frame-start position (0,0), the active pixels, and the last active
//   position (H_IMG_RES-1, V_IMG_RES-1), which closes the frame.
// ---------------------------------------------------------------------------
module motion_bbox #(
    parameter int H_IMG_RES  = 640,
    parameter int V_IMG_RES  = 480,
    parameter int MIN_PIXELS = 16,
    parameter int CNT_W      = 19
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [10:0]      hpos,
    input  logic [10:0]      vpos,
    input  logic             in_pix,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [10:0]      res_x_min,
    output logic [10:0]      res_x_max,
    output logic [10:0]      res_y_min,
    output logic [10:0]      res_y_max,
    output logic [CNT_W-1:0] res_count,
    output logic             res_motion,
    output logic             res_ovr
);

    // Compare limits in the 11-bit position width.
    localparam logic [10:0]      H_LIM   = 11'(H_IMG_RES);
    localparam logic [10:0]      V_LIM   = 11'(V_IMG_RES);
    localparam logic [10:0]      H_LAST  = 11'(H_IMG_RES - 1);
    localparam logic [10:0]      V_LAST  = 11'(V_IMG_RES - 1);
    localparam logic [10:0]      POS_MAX = 11'h7FF;
    localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(MIN_PIXELS);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {
        IDLE,
        ACCUM
    } state_t;

    state_t state;

    // Running accumulators for the frame in progress.
    logic [10:0]      acc_xmin;
    logic [10:0]      acc_xmax;
    logic [10:0]      acc_ymin;
    logic [10:0]      acc_ymax;
    logic [CNT_W-1:0] acc_cnt;

    // Accumulator values after the current pixel is taken into account.
    logic [10:0]      nxt_xmin;
    logic [10:0]      nxt_xmax;
    logic [10:0]      nxt_ymin;
    logic [10:0]      nxt_ymax;
    logic [CNT_W-1:0] nxt_cnt;

    logic active;
    logic frame_start;
    logic frame_end;
    logic acc_en;
    logic hit;
    logic accept;

    assign active      = (hpos < H_LIM) && (vpos < V_LIM);
    assign frame_start = (hpos == 11'd0) && (vpos == 11'd0);
    // The frame-start pixel is accumulated even while still in IDLE.
    assign acc_en      = (state == ACCUM) || frame_start;
    assign hit         = acc_en && active && in_pix;
    assign frame_end   = (state == ACCUM) && active && (hpos == H_LAST) && (vpos == V_LAST);
    assign accept      = res_valid && res_ready;

    // NOTE: every output of this combinational block gets a default before
    // the conditional update, so no path leaves a value held (no latch).
    always_comb begin
        nxt_xmin = acc_xmin;
        nxt_xmax = acc_xmax;
        nxt_ymin = acc_ymin;
        nxt_ymax = acc_ymax;
        nxt_cnt  = acc_cnt;
        if (hit) begin
            if (hpos < acc_xmin) nxt_xmin = hpos;
            if (hpos > acc_xmax) nxt_xmax = hpos;
            if (vpos < acc_ymin) nxt_ymin = vpos;
            if (vpos > acc_ymax) nxt_ymax = vpos;
            if (!(&acc_cnt))     nxt_cnt  = acc_cnt + CNT_ONE;
        end
    end

    // NOTE: all state below uses non-blocking assignments, so every register
    // samples the values from before the edge regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            acc_xmin   <= POS_MAX;
            acc_xmax   <= '0;
            acc_ymin   <= POS_MAX;
            acc_ymax   <= '0;
            acc_cnt    <= '0;
            res_valid  <= 1'b0;
            res_x_min  <= '0;
            res_x_max  <= '0;
            res_y_min  <= '0;
            res_y_max  <= '0;
            res_count  <= '0;
            res_motion <= 1'b0;
            res_ovr    <= 1'b0;
        end else begin
            case (state)
                IDLE:  if (frame_start) state <= ACCUM;
                ACCUM: state <= ACCUM;
                default: state <= IDLE;
            endcase

            if (frame_end) begin
                // Publish with the next-values so the closing pixel is counted.
                if (nxt_cnt == '0) begin
                    // An empty frame reports a zero box, not the cleared sentinels.
                    res_x_min <= '0;
                    res_x_max <= '0;
                    res_y_min <= '0;
                    res_y_max <= '0;
                end else begin
                    res_x_min <= nxt_xmin;
                    res_x_max <= nxt_xmax;
                    res_y_min <= nxt_ymin;
                    res_y_max <= nxt_ymax;
                end
                res_count  <= nxt_cnt;
                res_motion <= (nxt_cnt >= CNT_MIN);
                res_valid  <= 1'b1;

                // An unaccepted result being replaced sets the sticky flag.
                // If the old result is accepted on this same edge, nothing is
                // lost and the flag clears instead.
                if (accept) begin
                    res_ovr <= 1'b0;
                end else if (res_valid) begin
                    res_ovr <= 1'b1;
                end

                acc_xmin <= POS_MAX;
                acc_xmax <= '0;
                acc_ymin <= POS_MAX;
                acc_ymax <= '0;
                acc_cnt  <= '0;
            end else begin
                if (accept) begin
                    res_valid <= 1'b0;
                    res_ovr   <= 1'b0;
                end
                if (acc_en) begin
                    acc_xmin <= nxt_xmin;
                    acc_xmax <= nxt_xmax;
                    acc_ymin <= nxt_ymin;
                    acc_ymax <= nxt_ymax;
                    acc_cnt  <= nxt_cnt;
                end
            end
        end
    end

endmodule

// File: tb/tb_motion_bbox.sv
// ---------------------------------------------------------------------------
// tb_motion_bbox
//
// Directed bench for motion_bbox at the default 640x480 geometry. Frames are
// driven sparsely: the frame-start pixel, the pixels of interest, blanking
// positions, and the closing pixel (639,479). Expected values are computed
// by hand from the pixels placed in each frame.
// ---------------------------------------------------------------------------
module tb_motion_bbox;

    localparam int CNT_W = 19;

    logic             clk;
    logic             rst_n;
    logic [10:0]      hpos;
    logic [10:0]      vpos;
    logic             in_pix;
    logic             res_valid;
    logic             res_ready;
    logic [10:0]      res_x_min;
    logic [10:0]      res_x_max;
    logic [10:0]      res_y_min;
    logic [10:0]      res_y_max;
    logic [CNT_W-1:0] res_count;
    logic             res_motion;
    logic             res_ovr;

    int n_tests;
    int n_fail;

    motion_bbox #(
        .H_IMG_RES (640),
        .V_IMG_RES (480),
        .MIN_PIXELS(16),
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hpos      (hpos),
        .vpos      (vpos),
        .in_pix    (in_pix),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_x_min (res_x_min),
        .res_x_max (res_x_max),
        .res_y_min (res_y_min),
        .res_y_max (res_y_max),
        .res_count (res_count),
        .res_motion(res_motion),
        .res_ovr   (res_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Present one pixel, let it be sampled, return #1 after the edge.
    task automatic send(input int h, input int v, input logic p);
        hpos   = 11'(h);
        vpos   = 11'(v);
        in_pix = p;
        @(posedge clk);
        #1;
    endtask

    // Park the raster in horizontal blanking.
    task automatic blank();
        hpos   = 11'd800;
        vpos   = 11'd0;
        in_pix = 1'b0;
    endtask

    // One-cycle accept of the current result.
    task automatic accept();
        blank();
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
    endtask

    task automatic check_res(input string tag, input int xmin, input int xmax,
                             input int ymin, input int ymax, input int cnt,
                             input logic mot);
        check({tag, ".valid"},  res_valid,  1);
        check({tag, ".x_min"},  res_x_min,  xmin);
        check({tag, ".x_max"},  res_x_max,  xmax);
        check({tag, ".y_min"},  res_y_min,  ymin);
        check({tag, ".y_max"},  res_y_max,  ymax);
        check({tag, ".count"},  res_count,  cnt);
        check({tag, ".motion"}, res_motion, mot);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        res_ready = 1'b0;
        blank();

        // Reset state.
        #3;
        check("rst.valid",  res_valid,  0);
        check("rst.count",  res_count,  0);
        check("rst.x_min",  res_x_min,  0);
        check("rst.motion", res_motion, 0);
        check("rst.ovr",    res_ovr,    0);
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: empty frame, latency of one clock after (639,479).
        send(0, 0, 0);
        for (int x = 0; x < 640; x++) send(x, 1, 0);
        send(638, 479, 0);
        check("t1.valid_before_end", res_valid, 0);
        send(639, 479, 0);
        blank();
        check_res("t1", 0, 0, 0, 0, 0, 0);
        check("t1.ovr", res_ovr, 0);
        accept();
        check("t1.valid_after_accept", res_valid, 0);

        // 2: single pixel.
        send(0, 0, 0);
        send(100, 50, 1);
        send(639, 479, 0);
        blank();
        check_res("t2", 100, 100, 50, 50, 1, 0);
        accept();

        // 3: 5x5 block plus the closing pixel itself.
        send(0, 0, 0);
        for (int y = 20; y <= 24; y++)
            for (int x = 10; x <= 14; x++)
                send(x, y, 1);
        send(639, 479, 1);
        blank();
        check_res("t3", 10, 639, 20, 479, 26, 1);
        accept();

        // 4: two frames without ready -> overwrite.
        send(0, 0, 0);
        for (int x = 1; x <= 3; x++) send(x, 1, 1);
        send(639, 479, 0);
        blank();
        check_res("t4a", 1, 3, 1, 1, 3, 0);
        check("t4a.ovr", res_ovr, 0);
        send(0, 0, 0);
        for (int x = 5; x <= 11; x++) send(x, 7, 1);
        send(639, 479, 0);
        blank();
        check_res("t4b", 5, 11, 7, 7, 7, 0);
        check("t4b.ovr", res_ovr, 1);
        accept();
        check("t4.valid_after_accept", res_valid, 0);
        check("t4.ovr_after_accept",   res_ovr,   0);

        // 5: set pixels only in blanking.
        send(0, 0, 0);
        send(700, 10, 1);
        send(10, 500, 1);
        send(639, 479, 0);
        blank();
        check_res("t5", 0, 0, 0, 0, 0, 0);

        // 5b: overwrite, then frame end coinciding with acceptance.
        send(0, 0, 0);
        send(300, 300, 1);
        send(639, 479, 0);
        blank();
        check("t5b.ovr_set", res_ovr, 1);
        check("t5b.count1",  res_count, 1);
        send(0, 0, 0);
        send(4, 9, 1);
        send(6, 9, 1);
        res_ready = 1'b1;
        send(639, 479, 0);
        res_ready = 1'b0;
        blank();
        check_res("t5b", 4, 6, 9, 9, 2, 0);
        check("t5b.ovr_cleared", res_ovr, 0);

        // 6: reset in the middle of a frame (result from 5b still pending).
        send(0, 0, 0);
        send(5, 100, 1);
        send(8, 200, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6.rst_valid", res_valid, 0);
        check("t6.rst_count", res_count, 0);
        #2 rst_n = 1'b1;
        send(7, 210, 1);
        send(639, 479, 1);
        blank();
        check("t6.no_result", res_valid, 0);
        send(0, 0, 0);
        send(30, 40, 1);
        send(639, 479, 0);
        blank();
        check_res("t6", 30, 30, 40, 40, 1, 0);
        accept();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
